sram_bank_sequencer: RTL

//  Upstream driver for sram_2port_bank. Accepts one read or write request per Bennett cycle over a

---
 rtl/sram_seq_pkg.sv | 23 ++
 rtl/bennett_edge_detect.sv | 26 ++
 rtl/sram_bank_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_seq_pkg.sv
// Shared state encoding and Bennett phase assignments for the SRAM bank sequencer.
package sram_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ARM,
        ADDR,
        DATA,
        CTRL,
        EN,
        ENOFF,
        RWB,
        FIN
    } seq_state_t;

    localparam int PH_START = 0;
    localparam int PH_ADDR  = 2;
    localparam int PH_DATA  = 4;
    localparam int PH_CTRL  = 6;
    localparam int PH_WEN   = 8;
    localparam int PH_WOFF  = 9;

endpackage

// File: rtl/bennett_edge_detect.sv
// Per-phase rise/fall detection of the Bennett phase bus, sampled on clk.
module bennett_edge_detect #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] clkp,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] clkp_q_reg;

    // The delayed copy tracks the bus during reset too, so release never sees a stale edge.
    always_ff @(posedge clk) begin
        clkp_q_reg <= clkp;
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
            assign rise[gi] = reset &  clkp[gi] & ~clkp_q_reg[gi];
            assign fall[gi] = reset & ~clkp[gi] &  clkp_q_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/sram_bank_sequencer.sv
// Sequences one read/write request per Bennett cycle onto sram_2port_bank and returns its outputs.
module sram_bank_sequencer
    import sram_seq_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  clkp,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] din,
    output logic              read_en,
    output logic              write_en,
    output logic              reg_wrt_bar,
    input  logic [DATA_W-1:0] dout_a,
    input  logic [DATA_W-1:0] dout_b,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data_a,
    output logic [DATA_W-1:0] rsp_data_b
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int PH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] rise, fall;

    bennett_edge_detect #(.WIDTH(WIDTH)) u_edge (
        .clk   (clk),
        .reset (reset),
        .clkp  (clkp),
        .rise  (rise),
        .fall  (fall)
    );

    seq_state_t        state_reg, state_next;
    logic              req_write_reg, req_write_next;
    logic [ADDR_W-1:0] req_addr_a_reg, req_addr_a_next;
    logic [ADDR_W-1:0] req_addr_b_reg, req_addr_b_next;
    logic [DATA_W-1:0] req_wdata_reg, req_wdata_next;
    logic [ADDR_W-1:0] addr_a_reg, addr_a_next;
    logic [ADDR_W-1:0] addr_b_reg, addr_b_next;
    logic [DATA_W-1:0] din_reg, din_next;
    logic              read_en_reg, read_en_next;
    logic              write_en_reg, write_en_next;
    logic              reg_wrt_bar_reg, reg_wrt_bar_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic              rsp_err_reg, rsp_err_next;
    logic [DATA_W-1:0] rsp_data_a_reg, rsp_data_a_next;
    logic [DATA_W-1:0] rsp_data_b_reg, rsp_data_b_next;
    logic [TO_W-1:0]   timeout_reg, timeout_next;
    logic [PH_W-1:0]   wait_phase;
    logic              use_fall;
    logic              edge_hit;

    always_comb begin
        state_next       = state_reg;
        req_write_next   = req_write_reg;
        req_addr_a_next  = req_addr_a_reg;
        req_addr_b_next  = req_addr_b_reg;
        req_wdata_next   = req_wdata_reg;
        addr_a_next      = addr_a_reg;
        addr_b_next      = addr_b_reg;
        din_next         = din_reg;
        read_en_next     = read_en_reg;
        write_en_next    = write_en_reg;
        reg_wrt_bar_next = reg_wrt_bar_reg;
        rsp_valid_next   = 1'b0;
        rsp_err_next     = 1'b0;
        rsp_data_a_next  = rsp_data_a_reg;
        rsp_data_b_next  = rsp_data_b_reg;
        wait_phase       = PH_W'(PH_START);
        use_fall         = 1'b0;

        // Only the single edge the current state waits on may advance it.
        case (state_reg)
            ADDR:    wait_phase = PH_W'(PH_ADDR);
            DATA:    wait_phase = PH_W'(PH_DATA);
            CTRL:    wait_phase = PH_W'(PH_CTRL);
            EN:      wait_phase = PH_W'(PH_WEN);
            ENOFF:   wait_phase = PH_W'(PH_WOFF);
            RWB: begin
                wait_phase = PH_W'(PH_CTRL);
                use_fall   = 1'b1;
            end
            FIN:     use_fall = 1'b1;
            default: ;
        endcase
        edge_hit = use_fall ? fall[wait_phase] : rise[wait_phase];

        case (state_reg)
            IDLE: if (req_valid) begin
                req_write_next  = req_write;
                req_addr_a_next = req_addr_a;
                req_addr_b_next = req_addr_b;
                req_wdata_next  = req_wdata;
                state_next      = ARM;
            end
            ARM: if (edge_hit) state_next = ADDR;
            ADDR: if (edge_hit) begin
                addr_a_next = req_addr_a_reg;
                addr_b_next = req_addr_b_reg;
                state_next  = DATA;
            end
            DATA: if (edge_hit) begin
                din_next   = req_write_reg ? req_wdata_reg : '0;
                state_next = CTRL;
            end
            CTRL: if (edge_hit) begin
                if (req_write_reg) reg_wrt_bar_next = 1'b1;
                else               read_en_next     = 1'b1;
                state_next = EN;
            end
            EN: if (edge_hit) begin
                if (req_write_reg) write_en_next = 1'b1;
                else               read_en_next  = 1'b0;
                state_next = ENOFF;
            end
            ENOFF: if (edge_hit) begin
                write_en_next = 1'b0;
                state_next    = req_write_reg ? RWB : FIN;
            end
            RWB: if (edge_hit) begin
                reg_wrt_bar_next = 1'b0;
                state_next       = FIN;
            end
            FIN: if (edge_hit) begin
                if (!req_write_reg) begin
                    rsp_data_a_next = dout_a;
                    rsp_data_b_next = dout_b;
                end
                rsp_valid_next = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A stalled phase bus aborts the request and leaves the bank disabled.
        if (state_reg != IDLE && !edge_hit && timeout_reg == TO_W'(TIMEOUT - 1)) begin
            read_en_next     = 1'b0;
            write_en_next    = 1'b0;
            reg_wrt_bar_next = 1'b0;
            rsp_valid_next   = 1'b1;
            rsp_err_next     = 1'b1;
            state_next       = IDLE;
        end

        timeout_next = (state_reg == IDLE || state_next != state_reg) ? '0 : timeout_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            req_write_reg   <= 1'b0;
            req_addr_a_reg  <= '0;
            req_addr_b_reg  <= '0;
            req_wdata_reg   <= '0;
            addr_a_reg      <= '0;
            addr_b_reg      <= '0;
            din_reg         <= '0;
            read_en_reg     <= 1'b0;
            write_en_reg    <= 1'b0;
            reg_wrt_bar_reg <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_err_reg     <= 1'b0;
            rsp_data_a_reg  <= '0;
            rsp_data_b_reg  <= '0;
            timeout_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            req_write_reg   <= req_write_next;
            req_addr_a_reg  <= req_addr_a_next;
            req_addr_b_reg  <= req_addr_b_next;
            req_wdata_reg   <= req_wdata_next;
            addr_a_reg      <= addr_a_next;
            addr_b_reg      <= addr_b_next;
            din_reg         <= din_next;
            read_en_reg     <= read_en_next;
            write_en_reg    <= write_en_next;
            reg_wrt_bar_reg <= reg_wrt_bar_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_data_a_reg  <= rsp_data_a_next;
            rsp_data_b_reg  <= rsp_data_b_next;
            timeout_reg     <= timeout_next;
        end
    end

    assign req_ready   = (state_reg == IDLE);
    assign addr_a      = addr_a_reg;
    assign addr_b      = addr_b_reg;
    assign din         = din_reg;
    assign read_en     = read_en_reg;
    assign write_en    = write_en_reg;
    assign reg_wrt_bar = reg_wrt_bar_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_data_a  = rsp_data_a_reg;
    assign rsp_data_b  = rsp_data_b_reg;

    a_en_exclusive: assert property (@(posedge clk) disable iff (!reset)
        !(read_en_reg && write_en_reg));

endmodule
